cfg_chain_loader: RTL and testbench

//  Frame sequencer for the daisy-chained configuration bit stream. Accepts a

---
 rtl/cfg_chain_loader_if.sv | 28 ++
 rtl/cfg_chain_loader.sv | 216 +++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
// Host/chain handshake bundle for cfg_chain_loader: command and payload
// valid/ready channels plus the serial chain-head outputs and status.
interface cfg_chain_loader_if #(
  parameter int ID_WIDTH = 3,
  parameter int WORD_W   = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ID_WIDTH-1:0] cmd_id;
  logic                data_valid;
  logic                data_ready;
  logic [WORD_W-1:0]   data;
  logic                cfg_in_start;
  logic                cfg_bit_in;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_id, data_valid, data,
    input  cmd_ready, data_ready, cfg_in_start, cfg_bit_in, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_id, data_valid, data,
    output cmd_ready, data_ready, cfg_in_start, cfg_bit_in, busy, done, err
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// Frame sequencer for the daisy-chained config stream: start pulse, tile ID
// header, zero-padded payload, drain, done. All outputs registered.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// FILL   | command latched, waiting for the first payload word
// START  | cfg_in_start pulse cycle
// HEADER | shifting out the tile ID, LSB first
// DATA   | shifting out FRAME_BITS payload bits
// DRAIN  | zero cycles after payload, done in the last one
module cfg_chain_loader #(
  parameter int ID_WIDTH     = 3,
  parameter int SHIFT_LEN    = 16,
  parameter int CFG_SIZE     = 256,
  parameter int WORD_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cfg_chain_loader_if.slave bus
);
  localparam int FRAME_BITS = ((CFG_SIZE + SHIFT_LEN - 1) / SHIFT_LEN) * SHIFT_LEN;
  localparam int NUM_WORDS  = (FRAME_BITS + WORD_W - 1) / WORD_W;
  localparam int BCNT_W     = $clog2(FRAME_BITS + 1);
  localparam int WCNT_W     = $clog2(NUM_WORDS + 1);
  localparam int WPOS_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TMR_MAX    = (ID_WIDTH > DRAIN_CYCLES) ? ID_WIDTH : DRAIN_CYCLES;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [BCNT_W-1:0] FRAME_BITS_C = BCNT_W'(FRAME_BITS);
  localparam logic [BCNT_W-1:0] CFG_SIZE_C   = BCNT_W'(CFG_SIZE);
  localparam logic [WCNT_W-1:0] NUM_WORDS_C  = WCNT_W'(NUM_WORDS);
  localparam logic [WPOS_W-1:0] WPOS_LAST    = WPOS_W'(WORD_W - 1);
  localparam logic [TMR_W-1:0]  HDR_LOAD     = TMR_W'(ID_WIDTH - 1);
  localparam logic [TMR_W-1:0]  DRAIN_LOAD   = TMR_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FILL, START, HEADER, DATA, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [WORD_W-1:0]   act_q, act_d;
  logic [WORD_W-1:0]   pre_q, pre_d;
  logic                pre_full_q, pre_full_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WPOS_W-1:0]   wpos_q, wpos_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic                bit_q, bit_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                data_ready_q, data_ready_d;
  logic                data_hs, emit, moved, bypass;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    act_d      = act_q;
    pre_d      = pre_q;
    pre_full_d = pre_full_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    wpos_d     = wpos_q;
    tmr_d      = tmr_q;
    err_d      = err_q;
    start_d    = 1'b0;
    bit_d      = 1'b0;
    done_d     = 1'b0;
    emit       = 1'b0;
    moved      = 1'b0;
    bypass     = 1'b0;
    data_hs    = bus.data_valid & data_ready_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d    = FILL;
          id_d       = bus.cmd_id;
          err_d      = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          wpos_d     = '0;
          pre_full_d = 1'b0;
        end
      end
      FILL: begin
        if (data_hs) begin
          state_d = START;
          start_d = 1'b1;
        end
      end
      START: begin
        state_d = HEADER;
        tmr_d   = HDR_LOAD;
        bit_d   = id_q[0];
        id_d    = id_q >> 1;
      end
      HEADER: begin
        if (tmr_q == '0) begin
          state_d = DATA;
          emit    = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
          bit_d = id_q[0];
          id_d  = id_q >> 1;
        end
      end
      DATA: begin
        if (bit_cnt_q == FRAME_BITS_C) begin
          state_d = DRAIN;
          tmr_d   = DRAIN_LOAD;
          done_d  = (DRAIN_CYCLES == 1);
        end else begin
          emit = 1'b1;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d  = tmr_q - 1'b1;
          done_d = (tmr_q == TMR_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    // After an underrun err_q forces zeros, which also discards late words.
    if (emit) begin
      bit_d     = act_q[0] & ~err_q & (bit_cnt_q < CFG_SIZE_C);
      act_d     = act_q >> 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (wpos_q == WPOS_LAST) begin
        wpos_d = '0;
        if ((bit_cnt_q + 1'b1) < FRAME_BITS_C) begin
          if (pre_full_q) begin
            act_d = pre_q;
            moved = 1'b1;
          end else if (data_hs) begin
            act_d  = bus.data;
            bypass = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        wpos_d = wpos_q + 1'b1;
      end
    end

    if (moved) pre_full_d = 1'b0;
    if (data_hs) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (state_q == FILL) begin
        act_d = bus.data;
      end else if (!bypass) begin
        pre_d      = bus.data;
        pre_full_d = 1'b1;
      end
    end

    busy_d       = (state_d != IDLE);
    cmd_ready_d  = (state_d == IDLE);
    data_ready_d = ~pre_full_d & (word_cnt_d < NUM_WORDS_C) &
                   ((state_d == FILL) | (state_d == START) |
                    (state_d == HEADER) | (state_d == DATA));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      act_q        <= '0;
      pre_q        <= '0;
      pre_full_q   <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      wpos_q       <= '0;
      tmr_q        <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      bit_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      act_q        <= act_d;
      pre_q        <= pre_d;
      pre_full_q   <= pre_full_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      wpos_q       <= wpos_d;
      tmr_q        <= tmr_d;
      err_q        <= err_d;
      start_q      <= start_d;
      bit_q        <= bit_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.data_ready   = data_ready_q;
  assign bus.cfg_in_start = start_q;
  assign bus.cfg_bit_in   = bit_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: two instances (CFG_SIZE 32 and 20)
// share one host stimulus; a monitor rebuilds each frame and checks it.
module tb_cfg_chain_loader;
  localparam int ID_W     = 3;
  localparam int WORD_W   = 16;
  localparam int PAY_BITS = 32;
  localparam int DRAIN    = 4;
  localparam int DONE_OFS = ID_W + PAY_BITS + DRAIN;
  localparam int LIMIT    = 300;

  typedef struct {
    int               start_cyc;
    logic [ID_W-1:0]  id;
    logic [31:0]      pay_a;
    logic [31:0]      pay_b;
    logic             err;
  } frame_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc   = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     last_start = -1000;
  int     mon_starts = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_chain_loader_if #(.ID_WIDTH(ID_W), .WORD_W(WORD_W)) bus_a ();
  cfg_chain_loader_if #(.ID_WIDTH(ID_W), .WORD_W(WORD_W)) bus_b ();

  assign bus_b.cmd_valid  = bus_a.cmd_valid;
  assign bus_b.cmd_id     = bus_a.cmd_id;
  assign bus_b.data_valid = bus_a.data_valid;
  assign bus_b.data       = bus_a.data;

  cfg_chain_loader #(.ID_WIDTH(ID_W), .SHIFT_LEN(16), .CFG_SIZE(32),
                     .WORD_W(WORD_W), .DRAIN_CYCLES(DRAIN))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  cfg_chain_loader #(.ID_WIDTH(ID_W), .SHIFT_LEN(16), .CFG_SIZE(20),
                     .WORD_W(WORD_W), .DRAIN_CYCLES(DRAIN))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, {bus_a.cmd_ready, bus_b.cmd_ready}, 2'b11);
    check({tag, "_outputs_a"}, {bus_a.cfg_in_start, bus_a.cfg_bit_in, bus_a.busy,
                                bus_a.done, bus_a.err, bus_a.data_ready}, 6'b0);
    check({tag, "_outputs_b"}, {bus_b.cfg_in_start, bus_b.cfg_bit_in, bus_b.busy,
                                bus_b.done, bus_b.err, bus_b.data_ready}, 6'b0);
  endtask

  // Monitor: offset 0 is the start pulse, then header, payload, drain.
  int              m_k = -1;
  frame_t          m_e;
  int              m_start;
  logic [ID_W-1:0] m_hdr;
  logic [31:0]     m_pa, m_pb;
  logic            m_busy_ok, m_drain_ok, m_lock_ok;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_k = -1;
    end else begin
      if (bus_a.cfg_in_start || bus_b.cfg_in_start) begin
        check("start_outside_frame", m_k, -1);
        mon_starts++;
        m_k        = 0;
        m_start    = cyc;
        m_hdr      = '0;
        m_pa       = '0;
        m_pb       = '0;
        m_busy_ok  = bus_a.busy & bus_b.busy;
        m_drain_ok = 1'b1;
        m_lock_ok  = (bus_a.cfg_in_start == bus_b.cfg_in_start);
      end else if (m_k >= 0) begin
        m_k++;
        if (m_k <= DONE_OFS) begin
          m_busy_ok = m_busy_ok & bus_a.busy & bus_b.busy;
          m_lock_ok = m_lock_ok & (bus_a.err == bus_b.err) & (bus_a.done == bus_b.done);
        end
        if (m_k >= 1 && m_k <= ID_W) m_hdr[m_k-1] = bus_a.cfg_bit_in;
        else if (m_k > ID_W && m_k <= ID_W + PAY_BITS) begin
          m_pa[m_k-ID_W-1] = bus_a.cfg_bit_in;
          m_pb[m_k-ID_W-1] = bus_b.cfg_bit_in;
        end else if (m_k > ID_W + PAY_BITS && m_k <= DONE_OFS)
          m_drain_ok = m_drain_ok & ~bus_a.cfg_bit_in & ~bus_b.cfg_bit_in;
      end
      if (bus_a.done || bus_b.done) check("done_offset", m_k, DONE_OFS);
      if (m_k == DONE_OFS) begin
        check("done_pulse", {bus_a.done, bus_b.done}, 2'b11);
        check("busy_through_frame", m_busy_ok, 1'b1);
        check("drain_zero", m_drain_ok, 1'b1);
        check("instances_lockstep", m_lock_ok, 1'b1);
        if (exp_q.size() == 0) begin
          check("expected_frame_available", exp_q.size(), 1);
        end else begin
          m_e = exp_q.pop_front();
          check("start_cycle", m_start, m_e.start_cyc);
          check("header_id", m_hdr, m_e.id);
          check("payload_cfg32", m_pa, m_e.pay_a);
          check("payload_cfg20", m_pb, m_e.pay_b);
          check("err_at_done", {bus_a.err, bus_b.err}, {m_e.err, m_e.err});
        end
      end else if (m_k == DONE_OFS + 1) begin
        check("idle_after_done", {bus_a.cmd_ready, bus_a.busy, bus_b.cmd_ready, bus_b.busy},
              4'b1010);
        m_k = -1;
      end
    end
  end

  task automatic run_frame(input logic [ID_W-1:0] id, input logic [15:0] w0,
                           input logic [15:0] w1, input int g0, input int g1,
                           input bit rst_mid);
    int     t_cmd, f, h1, tmo, snap;
    bit     was_busy;
    frame_t e;
    @(negedge clk);
    was_busy         = bus_a.busy;
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_id     = id;
    tmo = 0;
    while (!bus_a.cmd_ready && tmo < LIMIT) begin
      @(negedge clk);
      tmo++;
    end
    check("cmd_accepted", bus_a.cmd_ready, 1'b1);
    t_cmd = cyc;
    snap  = mon_starts;
    if (was_busy) check("b2b_accept_cycle", t_cmd, last_start + 40);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    repeat (g0) @(negedge clk);
    if (g0 > 50) begin
      check("fill_stall_busy", bus_a.busy, 1'b1);
      check("fill_stall_no_start", mon_starts, snap);
    end
    bus_a.data_valid = 1'b1;
    bus_a.data       = w0;
    tmo = 0;
    while (!bus_a.data_ready && tmo < LIMIT) begin
      @(negedge clk);
      tmo++;
    end
    check("word0_accepted", bus_a.data_ready, 1'b1);
    f = cyc;
    @(negedge clk);
    bus_a.data_valid = 1'b0;
    repeat (g1 - 1) @(negedge clk);
    bus_a.data_valid = 1'b1;
    bus_a.data       = w1;
    tmo = 0;
    while (!bus_a.data_ready && tmo < LIMIT) begin
      @(negedge clk);
      tmo++;
    end
    check("word1_accepted", bus_a.data_ready, 1'b1);
    h1 = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_a.data = 16'($urandom);
      check("extra_word_refused", bus_a.data_ready, 1'b0);
    end
    bus_a.data_valid = 1'b0;

    // Word 1 must be in hand before the cycle that shows word 0's last bit.
    e.start_cyc = f + 1;
    e.id        = id;
    e.err       = (h1 >= e.start_cyc + ID_W + WORD_W);
    e.pay_a     = e.err ? {16'h0000, w0} : {w1, w0};
    e.pay_b     = e.pay_a & 32'h000F_FFFF;
    last_start  = e.start_cyc;
    if (!rst_mid) begin
      exp_q.push_back(e);
    end else begin
      while (cyc < e.start_cyc + 13) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_idle("mid_reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
    end
  endtask

  initial begin
    int tmo;
    bus_a.cmd_valid  = 1'b0;
    bus_a.cmd_id     = '0;
    bus_a.data_valid = 1'b0;
    bus_a.data       = '0;
    repeat (3) @(posedge clk);
    #2 check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(3'd5, 16'hA5A5, 16'h0F0F, 0, 1, 1'b0);
    run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom), 0, 21, 1'b0);
    run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom), 0, 19, 1'b0);
    run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom), 0, 20, 1'b0);
    run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom), 100, 1, 1'b0);
    run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom), 0, 2, 1'b1);
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 50)) @(negedge clk);
      run_frame(ID_W'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(1, 28), 1'b0);
    end

    tmo = 0;
    while ((exp_q.size() != 0 || m_k != -1) && tmo < LIMIT) begin
      @(negedge clk);
      tmo++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
